instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 115 +++++++++++
 tb/tb_instr_fetch.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: requests words from instruction memory, presents them to decode,
// and steers the fetch PC on accept using the branch controls; stops on HALT_WORD.
module instr_fetch #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] HALT_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [63:0] pc,
    output logic        instr_valid,
    input  logic        instr_accept,
    input  logic        branch,
    input  logic        branch_if_zero,
    input  logic        branch_if_not_zero,
    input  logic        zero,
    input  logic [63:0] extended_instruction,
    output logic        halted,
    output logic [31:0] retired_count
);

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;
    localparam int unsigned CNTW = 32;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_HALT  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [ILEN-1:0]   instr_q, instr_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              valid_q, valid_d;
    logic              halted_q, halted_d;
    logic              taken_c;

    // State and output registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            fetch_pc_q <= RESET_PC;
            pc_q       <= RESET_PC;
            instr_q    <= ILEN'(0);
            cnt_q      <= CNTW'(0);
            req_q      <= 1'b1;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
            halted_q   <= halted_d;
        end
    end

    // Next-state logic; status outputs are derived from the next state so they stay registered.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        cnt_d      = cnt_q;
        taken_c    = branch | (branch_if_zero & zero) | (branch_if_not_zero & ~zero);

        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    if (imem_rdata == HALT_WORD) begin
                        state_d = S_HALT;
                    end else begin
                        instr_d = imem_rdata;
                        pc_d    = fetch_pc_q;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (instr_accept) begin
                    fetch_pc_d = taken_c ? (pc_q + (extended_instruction << 2))
                                         : (pc_q + XLEN'(4));
                    cnt_d      = cnt_q + CNTW'(1);
                    state_d    = S_FETCH;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase

        req_d    = (state_d == S_FETCH);
        valid_d  = (state_d == S_HOLD);
        halted_d = (state_d == S_HALT);
    end

    assign imem_req      = req_q;
    assign imem_addr     = fetch_pc_q;
    assign instruction   = instr_q;
    assign pc            = pc_q;
    assign instr_valid   = valid_q;
    assign halted        = halted_q;
    assign retired_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus queues expected (instruction, pc) pairs,
// a monitor pops them whenever a new instruction is presented to decode.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [63:0] pc;
    logic        instr_valid;
    logic        instr_accept;
    logic        branch;
    logic        branch_if_zero;
    logic        branch_if_not_zero;
    logic        zero;
    logic [63:0] extended_instruction;
    logic        halted;
    logic [31:0] retired_count;

    typedef struct packed {
        logic [31:0] ins;
        logic [63:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk                  (clk),
        .reset                (reset),
        .imem_req             (imem_req),
        .imem_addr            (imem_addr),
        .imem_ready           (imem_ready),
        .imem_rdata           (imem_rdata),
        .instruction          (instruction),
        .pc                   (pc),
        .instr_valid          (instr_valid),
        .instr_accept         (instr_accept),
        .branch               (branch),
        .branch_if_zero       (branch_if_zero),
        .branch_if_not_zero   (branch_if_not_zero),
        .zero                 (zero),
        .extended_instruction (extended_instruction),
        .halted               (halted),
        .retired_count        (retired_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one word in FETCH at the expected address; leaves the DUT in HOLD.
    task automatic fetch(input logic [31:0] word, input logic [63:0] addr);
        check("fetch_req", 64'(imem_req), 64'd1);
        check("fetch_addr", imem_addr, addr);
        check("fetch_valid_low", 64'(instr_valid), 64'd0);
        imem_ready = 1'b1;
        imem_rdata = word;
        exp_q.push_back('{ins: word, pc: addr});
        step();
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        check("hold_req_low", 64'(imem_req), 64'd0);
    endtask

    task automatic accept(input logic br, input logic bz, input logic bnz,
                          input logic z, input logic [63:0] ext);
        instr_accept         = 1'b1;
        branch               = br;
        branch_if_zero       = bz;
        branch_if_not_zero   = bnz;
        zero                 = z;
        extended_instruction = ext;
        step();
        instr_accept         = 1'b0;
        branch               = 1'b0;
        branch_if_zero       = 1'b0;
        branch_if_not_zero   = 1'b0;
        zero                 = 1'b0;
        extended_instruction = 64'h0;
    endtask

    // Monitor: compare each newly presented instruction against the scoreboard.
    initial begin
        logic valid_prev;
        exp_t e;
        valid_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (instr_valid && !valid_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL mon_unexpected: got instruction %h pc %h expected none", instruction, pc);
                end else begin
                    e = exp_q.pop_front();
                    check("mon_instruction", 64'(instruction), 64'(e.ins));
                    check("mon_pc", pc, e.pc);
                end
            end
            valid_prev = instr_valid;
        end
    end

    initial begin
        reset = 1'b1; imem_ready = 1'b0; imem_rdata = 32'h0; instr_accept = 1'b0;
        branch = 1'b0; branch_if_zero = 1'b0; branch_if_not_zero = 1'b0; zero = 1'b0;
        extended_instruction = 64'h0;
        step();
        // imem_ready during reset must be discarded
        imem_ready = 1'b1; imem_rdata = 32'h1234_5678;
        step();
        reset = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0;
        check("rst_req", 64'(imem_req), 64'd1);
        check("rst_addr", imem_addr, 64'h0);
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_count", 64'(retired_count), 64'd0);
        check("rst_instruction", 64'(instruction), 64'd0);
        check("rst_pc", pc, 64'h0);

        // Sequential fetch
        fetch(32'h11, 64'h0);  accept(0, 0, 0, 0, 64'h0);
        fetch(32'h22, 64'h4);  accept(0, 0, 0, 0, 64'h0);
        fetch(32'h33, 64'h8);  accept(0, 0, 0, 0, 64'h0);
        check("seq_count", 64'(retired_count), 64'd3);
        check("seq_addr", imem_addr, 64'hC);

        // Branches: unconditional to 0x40, beqz taken/not-taken, bnez taken
        fetch(32'h44, 64'hC);   accept(1, 0, 0, 0, 64'd13);
        fetch(32'h55, 64'h40);  accept(0, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE);
        check("bz_taken_addr", imem_addr, 64'h38);
        fetch(32'h66, 64'h38);  accept(1, 0, 0, 1, 64'd2);
        fetch(32'h77, 64'h40);  accept(0, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE);
        check("bz_not_taken_addr", imem_addr, 64'h44);
        fetch(32'h88, 64'h44);  accept(0, 0, 1, 0, 64'd4);
        check("bnz_taken_addr", imem_addr, 64'h54);
        check("br_count", 64'(retired_count), 64'd8);

        // Accept outside HOLD is ignored
        accept(1, 0, 0, 0, 64'd100);
        check("ign_accept_addr", imem_addr, 64'h54);
        check("ign_accept_count", 64'(retired_count), 64'd8);

        // Stall five cycles, ready on the sixth
        for (int i = 0; i < 5; i++) begin
            check("stall_req", 64'(imem_req), 64'd1);
            check("stall_addr", imem_addr, 64'h54);
            check("stall_valid", 64'(instr_valid), 64'd0);
            step();
        end
        fetch(32'h99, 64'h54);
        check("stall_valid_after", 64'(instr_valid), 64'd1);
        // imem_ready in HOLD is ignored and the presented instruction holds
        imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step(); step();
        imem_ready = 1'b0; imem_rdata = 32'h0;
        check("hold_instruction", 64'(instruction), 64'h99);
        check("hold_pc", pc, 64'h54);
        check("hold_valid", 64'(instr_valid), 64'd1);
        accept(0, 0, 0, 0, 64'h0);
        check("hold_next_addr", imem_addr, 64'h58);

        // PC wrap past 2^64
        fetch(32'hAA, 64'h58);  accept(1, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFE9);
        check("pre_wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        fetch(32'hBB, 64'hFFFF_FFFF_FFFF_FFFC);  accept(0, 0, 0, 0, 64'h0);
        check("wrap_addr", imem_addr, 64'h0);
        check("wrap_count", 64'(retired_count), 64'd11);

        // Reset while accepting a taken branch in HOLD
        fetch(32'hCC, 64'h0);
        reset = 1'b1;
        accept(1, 0, 0, 0, 64'd5);
        reset = 1'b0;
        check("midrst_addr", imem_addr, 64'h0);
        check("midrst_valid", 64'(instr_valid), 64'd0);
        check("midrst_count", 64'(retired_count), 64'd0);
        check("midrst_req", 64'(imem_req), 64'd1);

        // Halt
        fetch(32'hDD, 64'h0);  accept(0, 0, 0, 0, 64'h0);
        imem_ready = 1'b1; imem_rdata = 32'h0;
        step();
        imem_ready = 1'b0;
        check("halt_halted", 64'(halted), 64'd1);
        check("halt_req", 64'(imem_req), 64'd0);
        check("halt_valid", 64'(instr_valid), 64'd0);
        check("halt_instruction", 64'(instruction), 64'hDD);
        for (int i = 0; i < 3; i++) begin
            imem_ready = 1'b1; imem_rdata = 32'h1111_0000;
            accept(1, 0, 0, 0, 64'd3);
            imem_ready = 1'b0;
        end
        check("halt_count", 64'(retired_count), 64'd1);
        check("halt_still", 64'(halted), 64'd1);
        check("halt_req_still", 64'(imem_req), 64'd0);
        check("halt_valid_still", 64'(instr_valid), 64'd0);

        step(); step();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
